// File: rtl/tl_buffer_pkg.sv
// Shared field widths and packed beat layouts for the TileLink-UH decoupling buffer.
package tl_buffer_pkg;

    localparam int unsigned TL_OPCODE_W = 3;
    localparam int unsigned TL_PARAM_W  = 3;
    localparam int unsigned TL_SIZE_W   = 3;
    localparam int unsigned TL_SOURCE_W = 4;
    localparam int unsigned TL_ADDR_W   = 32;
    localparam int unsigned TL_DATA_W   = 64;
    localparam int unsigned TL_MASK_W   = 8;

    // A-channel beat, most significant field first.
    typedef struct packed {
        logic [TL_OPCODE_W-1:0] opcode;
        logic [TL_PARAM_W-1:0]  param;
        logic [TL_SIZE_W-1:0]   size;
        logic [TL_SOURCE_W-1:0] source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_MASK_W-1:0]   mask;
        logic [TL_DATA_W-1:0]   data;
        logic                   corrupt;
    } tl_a_beat_t;

    // D-channel beat, most significant field first.
    typedef struct packed {
        logic [TL_OPCODE_W-1:0] opcode;
        logic [TL_SIZE_W-1:0]   size;
        logic [TL_SOURCE_W-1:0] source;
        logic                   denied;
        logic [TL_DATA_W-1:0]   data;
        logic                   corrupt;
    } tl_d_beat_t;

    localparam int unsigned TL_A_BEAT_W = $bits(tl_a_beat_t);  // 118
    localparam int unsigned TL_D_BEAT_W = $bits(tl_d_beat_t);  // 76

endpackage

// File: rtl/tl_buffer_queue.sv
// Generic ready/valid FIFO with registered occupancy. Ready and valid depend
// only on the stored count, so no combinational path crosses the queue.
module tl_buffer_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [WIDTH-1:0]             enq_data_i,
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output logic [WIDTH-1:0]             deq_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] enq_ptr_q;
    logic [PTR_W-1:0] enq_ptr_d;
    logic [PTR_W-1:0] deq_ptr_q;
    logic [PTR_W-1:0] deq_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             enq_fire_s;
    logic             deq_fire_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1'b1);
        end
    endfunction

    assign enq_ready_o = (count_q != FULL_CNT);
    assign deq_valid_o = (count_q != {CNT_W{1'b0}});
    assign enq_fire_s  = enq_valid_i & enq_ready_o;
    assign deq_fire_s  = deq_valid_o & deq_ready_i;
    assign deq_data_o  = mem_q[deq_ptr_q];
    assign count_o     = count_q;

    // Next-state for pointers and occupancy from the two handshakes.
    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        if (enq_fire_s) begin
            enq_ptr_d = ptr_next(enq_ptr_q);
        end else begin
            enq_ptr_d = enq_ptr_q;
        end
        if (deq_fire_s) begin
            deq_ptr_d = ptr_next(deq_ptr_q);
        end else begin
            deq_ptr_d = deq_ptr_q;
        end
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every in-flight beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enq_ptr_q <= {PTR_W{1'b0}};
            deq_ptr_q <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

    // Payload storage, written on enqueue only; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (enq_fire_s) begin
            mem_q[enq_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/tl_buffer.sv
// TileLink-UH decoupling buffer: one independent queue on A (in->out) and one
// on D (out->in). The top only packs/unpacks beats and forces the handshake
// outputs low while reset is held.
module tl_buffer
    import tl_buffer_pkg::*;
#(
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   auto_in_a_ready,
    input  logic                   auto_in_a_valid,
    input  logic [TL_OPCODE_W-1:0] auto_in_a_bits_opcode,
    input  logic [TL_PARAM_W-1:0]  auto_in_a_bits_param,
    input  logic [TL_SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [TL_SOURCE_W-1:0] auto_in_a_bits_source,
    input  logic [TL_ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [TL_MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [TL_DATA_W-1:0]   auto_in_a_bits_data,
    input  logic                   auto_in_a_bits_corrupt,
    input  logic                   auto_in_d_ready,
    output logic                   auto_in_d_valid,
    output logic [TL_OPCODE_W-1:0] auto_in_d_bits_opcode,
    output logic [TL_SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [TL_SOURCE_W-1:0] auto_in_d_bits_source,
    output logic                   auto_in_d_bits_denied,
    output logic [TL_DATA_W-1:0]   auto_in_d_bits_data,
    output logic                   auto_in_d_bits_corrupt,
    input  logic                   auto_out_a_ready,
    output logic                   auto_out_a_valid,
    output logic [TL_OPCODE_W-1:0] auto_out_a_bits_opcode,
    output logic [TL_PARAM_W-1:0]  auto_out_a_bits_param,
    output logic [TL_SIZE_W-1:0]   auto_out_a_bits_size,
    output logic [TL_SOURCE_W-1:0] auto_out_a_bits_source,
    output logic [TL_ADDR_W-1:0]   auto_out_a_bits_address,
    output logic [TL_MASK_W-1:0]   auto_out_a_bits_mask,
    output logic [TL_DATA_W-1:0]   auto_out_a_bits_data,
    output logic                   auto_out_a_bits_corrupt,
    output logic                   auto_out_d_ready,
    input  logic                   auto_out_d_valid,
    input  logic [TL_OPCODE_W-1:0] auto_out_d_bits_opcode,
    input  logic [TL_SIZE_W-1:0]   auto_out_d_bits_size,
    input  logic [TL_SOURCE_W-1:0] auto_out_d_bits_source,
    input  logic                   auto_out_d_bits_denied,
    input  logic [TL_DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                   auto_out_d_bits_corrupt
);

    tl_a_beat_t a_enq_beat_s;
    tl_a_beat_t a_deq_beat_s;
    tl_d_beat_t d_enq_beat_s;
    tl_d_beat_t d_deq_beat_s;
    logic       a_enq_ready_s;
    logic       a_deq_valid_s;
    logic       d_enq_ready_s;
    logic       d_deq_valid_s;

    assign a_enq_beat_s.opcode  = auto_in_a_bits_opcode;
    assign a_enq_beat_s.param   = auto_in_a_bits_param;
    assign a_enq_beat_s.size    = auto_in_a_bits_size;
    assign a_enq_beat_s.source  = auto_in_a_bits_source;
    assign a_enq_beat_s.address = auto_in_a_bits_address;
    assign a_enq_beat_s.mask    = auto_in_a_bits_mask;
    assign a_enq_beat_s.data    = auto_in_a_bits_data;
    assign a_enq_beat_s.corrupt = auto_in_a_bits_corrupt;

    assign d_enq_beat_s.opcode  = auto_out_d_bits_opcode;
    assign d_enq_beat_s.size    = auto_out_d_bits_size;
    assign d_enq_beat_s.source  = auto_out_d_bits_source;
    assign d_enq_beat_s.denied  = auto_out_d_bits_denied;
    assign d_enq_beat_s.data    = auto_out_d_bits_data;
    assign d_enq_beat_s.corrupt = auto_out_d_bits_corrupt;

    // A channel: request path from the width widget toward the crossbar.
    tl_buffer_queue #(
        .WIDTH (TL_A_BEAT_W),
        .DEPTH (A_DEPTH)
    ) u_a_queue (
        .clk_i       (clock),
        .rst_ni      (reset),
        .enq_valid_i (auto_in_a_valid & reset),
        .enq_ready_o (a_enq_ready_s),
        .enq_data_i  (a_enq_beat_s),
        .deq_valid_o (a_deq_valid_s),
        .deq_ready_i (auto_out_a_ready & reset),
        .deq_data_o  (a_deq_beat_s),
        .count_o     ()
    );

    // D channel: response path from the slave side back upstream.
    tl_buffer_queue #(
        .WIDTH (TL_D_BEAT_W),
        .DEPTH (D_DEPTH)
    ) u_d_queue (
        .clk_i       (clock),
        .rst_ni      (reset),
        .enq_valid_i (auto_out_d_valid & reset),
        .enq_ready_o (d_enq_ready_s),
        .enq_data_i  (d_enq_beat_s),
        .deq_valid_o (d_deq_valid_s),
        .deq_ready_i (auto_in_d_ready & reset),
        .deq_data_o  (d_deq_beat_s),
        .count_o     ()
    );

    // Occupancy is unknown before the first reset edge, so handshakes are
    // held low for as long as reset is asserted.
    assign auto_in_a_ready  = reset & a_enq_ready_s;
    assign auto_out_a_valid = reset & a_deq_valid_s;
    assign auto_out_d_ready = reset & d_enq_ready_s;
    assign auto_in_d_valid  = reset & d_deq_valid_s;

    assign auto_out_a_bits_opcode  = a_deq_beat_s.opcode;
    assign auto_out_a_bits_param   = a_deq_beat_s.param;
    assign auto_out_a_bits_size    = a_deq_beat_s.size;
    assign auto_out_a_bits_source  = a_deq_beat_s.source;
    assign auto_out_a_bits_address = a_deq_beat_s.address;
    assign auto_out_a_bits_mask    = a_deq_beat_s.mask;
    assign auto_out_a_bits_data    = a_deq_beat_s.data;
    assign auto_out_a_bits_corrupt = a_deq_beat_s.corrupt;

    assign auto_in_d_bits_opcode  = d_deq_beat_s.opcode;
    assign auto_in_d_bits_size    = d_deq_beat_s.size;
    assign auto_in_d_bits_source  = d_deq_beat_s.source;
    assign auto_in_d_bits_denied  = d_deq_beat_s.denied;
    assign auto_in_d_bits_data    = d_deq_beat_s.data;
    assign auto_in_d_bits_corrupt = d_deq_beat_s.corrupt;

endmodule

// File: doc/tl_buffer.md
Name: tl_buffer

Overview:
- Two-channel TileLink-UH decoupling buffer: one independent FIFO on the A channel (request, in→out) and one on the D channel (response, out→in).
- Sits directly downstream of the 64-bit width-widget stage, between it and the crossbar/slave port.
- Cuts combinational ready/valid paths in both directions. Data width is unchanged at 64 bits.

Parameters:
- A_DEPTH, 2, A-channel queue entries (≥1, any integer, not restricted to powers of two)
- D_DEPTH, 2, D-channel queue entries (≥1, any integer, not restricted to powers of two)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset asserted)
- auto_in_a_ready  out  1  A-queue not full
- auto_in_a_valid  in  1  upstream A beat valid
- auto_in_a_bits_{opcode,param,size}  in  3 each  A fields
- auto_in_a_bits_source  in  4  A source ID
- auto_in_a_bits_address  in  32  A address
- auto_in_a_bits_mask  in  8  byte mask
- auto_in_a_bits_data  in  64  A data
- auto_in_a_bits_corrupt  in  1  A corrupt flag
- auto_in_d_ready  in  1  upstream accepts D
- auto_in_d_valid  out  1  D-queue not empty
- auto_in_d_bits_{opcode,size}  out  3 each; auto_in_d_bits_source  out  4; auto_in_d_bits_denied  out  1; auto_in_d_bits_data  out  64; auto_in_d_bits_corrupt  out  1
- auto_out_a_ready  in  1  downstream accepts A
- auto_out_a_valid  out  1  A-queue not empty
- auto_out_a_bits_*  out  same widths as auto_in_a_bits_*
- auto_out_d_ready  out  1  D-queue not full
- auto_out_d_valid  in  1  downstream D valid
- auto_out_d_bits_*  in  same widths as auto_in_d_bits_*

Behaviour:
- Payloads are packed per beat: A = 118 bits (opcode, param, size, source, address, mask, data, corrupt); D = 76 bits (opcode, size, source, denied, data, corrupt). Every field is carried bit-exact and in order; no reordering, merging or dropping.
- Each queue keeps an enq pointer, a deq pointer (0..DEPTH-1, wrapping DEPTH-1→0) and a count (0..DEPTH, width clog2(DEPTH+1)).
- Enqueue side: enq_ready = (count != DEPTH). Enq fires when enq_valid && enq_ready; the payload is written at enq_ptr and enq_ptr advances.
- Dequeue side: deq_valid = (count != 0). The payload is driven from the storage entry at deq_ptr. Deq fires when deq_valid && deq_ready, and deq_ptr advances.
- count' = count + enq_fire − deq_fire. Simultaneous enq and deq fires leave count unchanged.
- No flow-through: a beat written in cycle N is visible at the output no earlier than cycle N+1. Minimum latency is 1 cycle; with empty queue and ready held high, throughput is 1 beat/cycle.
- No pipe mode: ready depends only on count, never combinationally on the downstream ready. When full, enq_ready=0 even if a deq fires in the same cycle.
- Full, DEPTH=2 case: 2 beats accepted back-to-back, then in_a_ready=0 until the first out_a fire; in_a_ready returns to 1 the cycle after that fire.
- Empty: out valid=0. Payload outputs then hold stale storage contents; they are don't-care and unchecked.
- Reset (reset==0 at a rising edge): pointers and counts clear to 0 and all in-flight beats are discarded, including when asserted mid-burst.
  - While reset==0: auto_out_a_valid=0, auto_in_d_valid=0, auto_in_a_ready=0, auto_out_d_ready=0.
  - First cycle after release: both readies = 1, both valids = 0.
- Storage arrays are not reset.
- No protocol checking or transformation; multi-beat bursts pass beat by beat.
- Deadlock-free under any independent A/D backpressure: the two queues share no state.

Decomposition:
- Package tl_buffer_pkg holds:
  - field width constants: TL_OPCODE_W=3, TL_PARAM_W=3, TL_SIZE_W=3, TL_SOURCE_W=4, TL_ADDR_W=32, TL_DATA_W=64, TL_MASK_W=8
  - packed typedefs tl_a_beat_t and tl_d_beat_t, with derived widths 118 and 76
- One generic sub-module, tl_buffer_queue (parameters WIDTH, DEPTH; enq/deq ready-valid; count), instantiated once per channel.
- The top level only packs/unpacks fields and gates the valid/ready outputs with reset.

Test Plan:
- Reset low 3 cycles, then high → during reset all valids/readies are 0; first cycle after release in_a_ready=1, out_d_ready=1, out_a_valid=0, in_d_valid=0.
- Single A beat (Get, source=4'h5, address=32'h8000_0040, mask=8'hFF), out_a_ready=1 → appears on out_a exactly 1 cycle later with all fields identical; count returns to 0.
- Backpressure: out_a_ready=0, push 3 beats with data 64'h1, 64'h2, 64'h3 → first 2 accepted, in_a_ready=0 while 3rd held; raise out_a_ready → outputs 1, 2, 3 in order, and 3rd accepted the cycle after the first deq.
- Streaming: 16 consecutive D beats with data 0..15, both readies high → one beat per cycle after 1-cycle latency, in order, denied/corrupt bits preserved.
- Simultaneous: queue holds 1 beat; enq and deq fire in same cycle → count stays 1, next output is the new beat; also pointer wrap at DEPTH=3 checked over 10 beats.
- Mid-operation reset with 2 A beats and 1 D beat queued → after release both valids=0, and no stale beat is ever emitted.
